// File: rtl/collector_pkg.sv
// collector_pkg: shared entry layout and channel ids for channel_collector.
// Entry is {[stamp,] ch, data}; COLLECTOR_TIMESTAMP_EN widens it to 13 bits.
package collector_pkg;
   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;
`ifdef COLLECTOR_TIMESTAMP_EN
   localparam int ENTRY_W = 13;
`else
   localparam int ENTRY_W = 5;
`endif
   localparam int DATA_LSB = 0;
   localparam int CH_BIT   = 4;
   localparam int TIME_LSB = 5;
endpackage

// File: rtl/collector_fifo.sv
// collector_fifo: synchronous FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module collector_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Empty reads as zero so stale storage never leaks out after reset.
   assign dout    = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/channel_collector.sv
// channel_collector: tags new nibbles from the left/right channels and queues them for a valid/ready reader.
// Define COLLECTOR_TIMESTAMP_EN to stamp each entry with an 8-bit cycle count on out_time.
module channel_collector
   import collector_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_left,
   input  logic [3:0]       dout_left,
   input  logic             en_right,
   input  logic [3:0]       dout_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_ch,
   output logic [3:0]       out_data,
`ifdef COLLECTOR_TIMESTAMP_EN
   output logic [7:0]       out_time,
`endif
   output logic [CNT_W-1:0] cnt_left,
   output logic [CNT_W-1:0] cnt_right,
   output logic             overflow,
   input  logic             clr_ovf
);
   logic               en_left_q, en_right_q;
   logic [3:0]         last_left, last_right;
   logic               ev_left, ev_right;
   logic               pend_valid, sel_valid, loser_valid, drop_loser;
   logic               accept, pop, full, empty, ovf_set;
   logic [ENTRY_W-1:0] pend, sel, loser, head, left_entry, right_entry;
`ifdef COLLECTOR_TIMESTAMP_EN
   logic [7:0] stamp;
   always_ff @(posedge clk) stamp <= rst ? 8'd0 : stamp + 8'd1;
   assign left_entry  = {stamp, CH_LEFT, dout_left};
   assign right_entry = {stamp, CH_RIGHT, dout_right};
   assign out_time    = head[TIME_LSB +: 8];
`else
   assign left_entry  = {CH_LEFT, dout_left};
   assign right_entry = {CH_RIGHT, dout_right};
`endif
   assign ev_left  = en_left & (~en_left_q | (dout_left != last_left));
   assign ev_right = en_right & (~en_right_q | (dout_right != last_right));
   // pend always drains when present, so a losing event can take its place; only a second loser is lost.
   always_comb begin
      sel_valid   = pend_valid | ev_left | ev_right;
      sel         = pend_valid ? pend : ev_left ? left_entry : right_entry;
      loser_valid = pend_valid ? (ev_left | ev_right) : (ev_left & ev_right);
      loser       = (pend_valid & ev_left) ? left_entry : right_entry;
      drop_loser  = pend_valid & ev_left & ev_right;
      pop         = out_valid & out_ready;
      accept      = sel_valid & (~full | pop);
      ovf_set     = (sel_valid & ~accept) | drop_loser;
   end
   collector_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (accept),
      .din  (sel),
      .pop  (pop),
      .dout (head),
      .full (full),
      .empty(empty)
   );
   assign out_valid = ~empty;
   assign out_ch    = head[CH_BIT];
   assign out_data  = head[DATA_LSB +: 4];
   always_ff @(posedge clk) begin
      if (rst) begin
         en_left_q  <= 1'b0;
         en_right_q <= 1'b0;
         last_left  <= '0;
         last_right <= '0;
         pend_valid <= 1'b0;
         pend       <= '0;
         cnt_left   <= '0;
         cnt_right  <= '0;
         overflow   <= 1'b0;
      end else begin
         en_left_q  <= en_left;
         en_right_q <= en_right;
         if (en_left) last_left <= dout_left;
         if (en_right) last_right <= dout_right;
         pend_valid <= loser_valid;
         if (loser_valid) pend <= loser;
         if (accept && sel[CH_BIT] == CH_LEFT && cnt_left != '1) cnt_left <= cnt_left + CNT_W'(1);
         if (accept && sel[CH_BIT] == CH_RIGHT && cnt_right != '1) cnt_right <= cnt_right + CNT_W'(1);
         overflow <= ovf_set ? 1'b1 : clr_ovf ? 1'b0 : overflow;
      end
   end
endmodule

// File: doc/channel_collector.md
Name: channel_collector

Overview:
- Downstream consumer of the lock/routing system's two output channels (en_left/dout_left, en_right/dout_right).
- Detects each new nibble delivered on either channel and tags it with its channel id.
- Queues tagged nibbles in a small FIFO and presents them to a reader over a valid/ready handshake.
- Keeps per-channel event counters and a sticky overflow flag for lab observation.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- CNT_W, 8, width of the per-channel saturating event counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en_left  input  1  left channel enable from the system stage.
- dout_left  input  4  left channel data, meaningful only while en_left=1.
- en_right  input  1  right channel enable from the system stage.
- dout_right  input  4  right channel data, meaningful only while en_right=1.
- out_valid  output  1  FIFO head entry is available.
- out_ready  input  1  reader accepts the head entry this cycle.
- out_ch  output  1  channel of the head entry: 0=left, 1=right.
- out_data  output  4  nibble of the head entry.
- cnt_left  output  CNT_W  left events accepted into the FIFO; saturates at all-ones.
- cnt_right  output  CNT_W  right events accepted into the FIFO; saturates at all-ones.
- overflow  output  1  sticky; set when any event is dropped.
- clr_ovf  input  1  clears overflow on the next edge.

Behaviour:
- Reset: out_valid=0, out_ch=0, out_data=0, cnt_left=0, cnt_right=0, overflow=0; FIFO empty; pending register empty; edge-history registers cleared (en_*_q=0, last_*=0).
- Event detection, per channel x: event_x = en_x & (~en_x_q | (dout_x != last_x)).
  - en_x_q and last_x are registered every cycle.
  - last_x updates only while en_x=1.
  - A steady enabled value therefore yields exactly one event.
- Arbitration:
  - One FIFO write per cycle.
  - Left wins a simultaneous event; the right event goes to a one-entry pending register (pend).
  - Next cycle, pend has priority over any new event on either channel. A losing new event goes to pend only if pend is freed this cycle; otherwise it is dropped and overflow is set.
- FIFO write:
  - Occurs when a selected entry exists and the FIFO is not full, or is full with a pop in the same cycle (simultaneous push+pop on full is allowed).
  - A write to a truly full FIFO is dropped, sets overflow, and does not increment counters.
- Read:
  - out_valid = ~empty.
  - Pop on out_valid & out_ready.
  - out_ch/out_data show the head combinationally from storage. They hold stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- Latency: an event at edge N is visible on out_valid after edge N+1 if it wrote directly; one cycle later if it went through pend.
- Counters increment on a successful FIFO write of their channel and saturate at all-ones (no wrap).
- overflow: set has priority over clr_ovf in the same cycle; otherwise clr_ovf clears it.
- Pointers: wrap at DEPTH. Count is held in a log2(DEPTH)+1-bit occupancy register.
- Reset mid-operation discards FIFO contents and pend. An enable already high at reset release counts as a new event.

Optional Feature:
- Macro: COLLECTOR_TIMESTAMP_EN.
- When defined:
  - Adds a free-running 8-bit cycle counter (reset to 0, wraps 255->0).
  - Each entry stores the counter value at event detection; pend keeps the original stamp.
  - Adds output port out_time [7:0] carrying the head entry's stamp.
- When undefined: no counter, no out_time port; entry width 5 bits.

Decomposition:
- Package collector_pkg holds:
  - CH_LEFT=1'b0 and CH_RIGHT=1'b1.
  - ENTRY_W: 5, or 13 with timestamp.
  - Entry field offsets.
- Sub-module collector_fifo: a generic sync FIFO of width ENTRY_W and depth DEPTH, with push/pop/full/empty and same-cycle push+pop on full.
- Detection, arbitration, counters and flags live in channel_collector.

Test Plan:
- Left only: reset; en_left=1 with dout_left=1010 held 3 cycles, then 0101 for 1 cycle; out_ready=1 -> entries (0,1010),(0,0101); cnt_left=2; overflow=0.
- Simultaneous: en_left and en_right rise together with 0011 and 1101 -> left entry first, right entry next cycle; cnt_left=1, cnt_right=1.
- Backpressure/full: out_ready=0; DEPTH+2 distinct right events, one per cycle -> out_valid=1 with head 1st value stable; exactly DEPTH entries stored; overflow=1; cnt_right=DEPTH.
- Push+pop on full: FIFO full and out_ready=1 as a new event arrives -> write accepted; overflow unchanged; occupancy stays DEPTH.
- Flags and reset: assert clr_ovf -> overflow=0 next edge. Assert rst with FIFO half full -> all outputs zero next edge; prior entries never appear.
- Timestamp (macro on): reset; left event at cycle 5 -> out_time=5. Simultaneous right event at cycle 9 -> right entry out_time=9, written at cycle 10.
